// File: rtl/kamus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kamus_pkg
// Description : Shared types for the kamus load/store unit: access width
//               encoding, LSU FSM state encoding, and the sizing helper for
//               the response timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package kamus_pkg;

  // Access width. 2'b11 is not a legal encoding.
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_X = 2'b11
  } mem_width_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  localparam int unsigned c_min_cnt_w = 8;

  // Counter wide enough to hold the timeout value, never below 8 bits.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w > c_min_cnt_w) ? w : c_min_cnt_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kamus_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : kamus_lsu_if
// Description : Data-memory bus between the LSU (master) and memory (slave).
//   data_req_o/data_we_o       request, write enable
//   data_addr_o                word-aligned address
//   data_be_o/data_wdata_o     byte enables, lane-replicated write data
//   data_gnt_i                 request accepted
//   data_rvalid_i/data_err_i   response valid, response error
//   data_rdata_i               response data
// Revision    : 1.0 - initial release
// ============================================================================
interface kamus_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/kamus_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : kamus_lsu_align
// Description : Combinational lane logic for the LSU.
//   i_width/i_addr_lo/i_we   access width, byte offset, store flag
//   i_unsigned               zero-extend loads
//   i_wdata/i_rdata          raw store data / raw bus read word
//   o_be/o_wdata             byte enables / lane-replicated store data
//   o_rdata                  shifted and extended load result
//   o_misaligned/o_illegal   alignment fault / illegal width encoding
// Revision    : 1.0 - initial release
// ============================================================================
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  mem_width_e  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_we,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [31:0] w_shifted;
  logic [3:0]  w_store_be;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    w_store_be   = 4'b1111;
    o_wdata      = i_wdata;
    o_rdata      = w_shifted;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_width)
      MEM_B: begin
        w_store_be = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_wdata[7:0]}};
        o_rdata    = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      MEM_H: begin
        w_store_be   = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        o_misaligned = i_addr_lo[0];
      end
      MEM_W: begin
        o_misaligned = |i_addr_lo;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  // Loads always fetch the whole word; lane selection happens on return.
  assign o_be = i_we ? w_store_be : 4'b1111;

endmodule
`default_nettype wire

// File: rtl/kamus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : kamus_lsu
// Description : Single-outstanding load/store unit, IDLE/REQ/WAIT/DONE FSM.
//   clk_i, rst_ni                   clock, async active-low reset
//   lsu_req_i .. lsu_wdata_i        request from EX, held until lsu_done_o
//   lsu_rdata_o, lsu_done_o         extended load result, completion pulse
//   lsu_busy_o                      stall while not IDLE
//   lsu_misaligned_o, lsu_err_o     exception flags, valid with lsu_done_o
//   bus                             data-memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module kamus_lsu
  import kamus_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_width_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_done_o,
  output logic        lsu_busy_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_err_o,
  kamus_lsu_if.master bus
);

  localparam int unsigned       c_cnt_w      = cnt_width(RSP_TIMEOUT);
  localparam bit                c_timeout_en = (RSP_TIMEOUT != 0);
  localparam logic [c_cnt_w-1:0] c_cnt_last  =
    c_timeout_en ? c_cnt_w'(RSP_TIMEOUT - 1) : '0;

  lsu_state_e         r_state, w_state_nxt;
  logic               r_we, r_unsigned, r_misaligned, r_err;
  mem_width_e         r_width;
  logic [31:0]        r_addr, r_wdata, r_rdata;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_idle, w_in_req, w_in_wait, w_in_done, w_accept, w_timeout;
  mem_width_e         w_width;
  logic [1:0]         w_addr_lo;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata, w_rdata_ext;
  logic               w_misaligned, w_illegal;

  assign w_idle    = (r_state == LSU_IDLE);
  assign w_in_req  = (r_state == LSU_REQ);
  assign w_in_wait = (r_state == LSU_WAIT);
  assign w_in_done = (r_state == LSU_DONE);
  assign w_accept  = w_idle & lsu_req_i;
  assign w_timeout = c_timeout_en & (r_cnt == c_cnt_last);

  // In IDLE the aligner looks at the live request so the accept decision
  // can see misalignment; afterwards it works from the captured copy.
  assign w_width   = w_idle ? mem_width_e'(lsu_width_i) : r_width;
  assign w_addr_lo = w_idle ? lsu_addr_i[1:0] : r_addr[1:0];

  kamus_lsu_align u_align (
    .i_width      (w_width),
    .i_addr_lo    (w_addr_lo),
    .i_we         (w_idle ? lsu_we_i : r_we),
    .i_unsigned   (w_idle ? lsu_unsigned_i : r_unsigned),
    .i_wdata      (w_idle ? lsu_wdata_i : r_wdata),
    .i_rdata      (bus.data_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata_ext),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= LSU_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE: if (lsu_req_i)
                  w_state_nxt = (w_misaligned | w_illegal) ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (bus.data_gnt_i) w_state_nxt = LSU_WAIT;
      LSU_WAIT: if (bus.data_rvalid_i | w_timeout) w_state_nxt = LSU_DONE;
      LSU_DONE: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we         <= 1'b0;
      r_width      <= MEM_B;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_misaligned <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_we         <= lsu_we_i;
      r_width      <= mem_width_e'(lsu_width_i);
      r_unsigned   <= lsu_unsigned_i;
      r_addr       <= lsu_addr_i;
      r_wdata      <= lsu_wdata_i;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_misaligned <= w_misaligned;
      r_err        <= w_illegal;
    end else if (w_in_wait) begin
      if (bus.data_rvalid_i) begin
        // A response beats a timeout landing on the same cycle.
        r_err   <= bus.data_err_i;
        r_rdata <= (r_we | bus.data_err_i) ? 32'h0 : w_rdata_ext;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign lsu_busy_o       = ~w_idle;
  assign lsu_done_o       = w_in_done;
  assign lsu_rdata_o      = w_in_done ? r_rdata : 32'h0;
  assign lsu_misaligned_o = w_in_done & r_misaligned;
  assign lsu_err_o        = w_in_done & r_err;

  // Bus outputs only carry values while a request is actually presented.
  assign bus.data_req_o   = w_in_req;
  assign bus.data_we_o    = w_in_req & r_we;
  assign bus.data_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.data_be_o    = w_in_req ? w_be : 4'h0;
  assign bus.data_wdata_o = w_in_req ? w_wdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_kamus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_kamus_lsu
// Description : Directed self-checking bench for kamus_lsu (RSP_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kamus_lsu;
  import kamus_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
  logic [1:0]  lsu_width_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_done_o, lsu_busy_o, lsu_misaligned_o, lsu_err_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  kamus_lsu_if bus ();

  kamus_lsu #(.RSP_TIMEOUT(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_width_i      (lsu_width_i),
    .lsu_unsigned_i   (lsu_unsigned_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_done_o       (lsu_done_o),
    .lsu_busy_o       (lsu_busy_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .lsu_err_o        (lsu_err_o),
    .bus              (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request in IDLE; the accept edge follows.
  task automatic issue(input logic we, input logic [1:0] width, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_width_i = width;
    lsu_unsigned_i = uns; lsu_addr_i = addr; lsu_wdata_i = wdata;
    #1;
    chk("idle_busy", {31'b0, lsu_busy_o}, 32'h0);
    chk("idle_req",  {31'b0, bus.data_req_o}, 32'h0);
    t0 = cyc;
    tick();
  endtask

  // REQ phase: hold gnt low for 'delay' cycles, then grant.
  task automatic req_phase(input string tag, input int delay, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata, input logic we);
    for (int i = 0; i < delay; i++) begin
      bus.data_gnt_i = 1'b0;
      #1;
      chk({tag, "_hold_req"},  {31'b0, bus.data_req_o}, 32'h1);
      chk({tag, "_hold_addr"}, bus.data_addr_o, addr);
      chk({tag, "_hold_be"},   {28'b0, bus.data_be_o}, {28'b0, be});
      chk({tag, "_hold_done"}, {31'b0, lsu_done_o}, 32'h0);
      tick();
    end
    bus.data_gnt_i = 1'b1;
    #1;
    chk({tag, "_req"},   {31'b0, bus.data_req_o}, 32'h1);
    chk({tag, "_addr"},  bus.data_addr_o, addr);
    chk({tag, "_be"},    {28'b0, bus.data_be_o}, {28'b0, be});
    chk({tag, "_wdata"}, bus.data_wdata_o, wdata);
    chk({tag, "_we"},    {31'b0, bus.data_we_o}, {31'b0, we});
    tick();
    bus.data_gnt_i = 1'b0;
  endtask

  task automatic rsp_phase(input string tag, input logic [31:0] rdata, input logic err);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = rdata; bus.data_err_i = err;
    #1;
    chk({tag, "_wait_req"}, {31'b0, bus.data_req_o}, 32'h0);
    tick();
    bus.data_rvalid_i = 1'b0; bus.data_err_i = 1'b0;
  endtask

  task automatic done_phase(input string tag, input logic [31:0] rdata,
                            input logic mis, input logic err, input int lat);
    lsu_req_i = 1'b0;
    #1;
    chk({tag, "_done"},  {31'b0, lsu_done_o}, 32'h1);
    chk({tag, "_rdata"}, lsu_rdata_o, rdata);
    chk({tag, "_mis"},   {31'b0, lsu_misaligned_o}, {31'b0, mis});
    chk({tag, "_err"},   {31'b0, lsu_err_o}, {31'b0, err});
    chk({tag, "_nreq"},  {31'b0, bus.data_req_o}, 32'h0);
    chk({tag, "_lat"},   cyc - t0, lat);
    tick();
    chk({tag, "_pulse"}, {31'b0, lsu_done_o}, 32'h0);
    chk({tag, "_idle"},  {31'b0, lsu_busy_o}, 32'h0);
  endtask

  initial begin
    rst_ni = 1'b0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_width_i = 2'b00; lsu_unsigned_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_err_i = 1'b0;
    bus.data_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy",  {31'b0, lsu_busy_o}, 32'h0);
    chk("rst_done",  {31'b0, lsu_done_o}, 32'h0);
    chk("rst_req",   {31'b0, bus.data_req_o}, 32'h0);
    chk("rst_be",    {28'b0, bus.data_be_o}, 32'h0);
    chk("rst_rdata", lsu_rdata_o, 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;
    tick();

    // SW word, immediate grant, response next cycle: done at cycle 3.
    issue(1'b1, MEM_W, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
    req_phase("sw", 0, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    rsp_phase("sw", 32'h0, 1'b0);
    done_phase("sw", 32'h0, 1'b0, 1'b0, 3);

    // LB from lane 3: 0x80 sign-extended.
    issue(1'b0, MEM_B, 1'b0, 32'h0000_2003, 32'h0);
    req_phase("lb", 0, 32'h0000_2000, 4'b1111, 32'h0, 1'b0);
    rsp_phase("lb", 32'h80FF_FFFF, 1'b0);
    done_phase("lb", 32'hFFFF_FF80, 1'b0, 1'b0, 3);

    // LBU from lane 3: zero-extended.
    issue(1'b0, MEM_B, 1'b1, 32'h0000_2003, 32'h0);
    req_phase("lbu", 0, 32'h0000_2000, 4'b1111, 32'h0, 1'b0);
    rsp_phase("lbu", 32'h80FF_FFFF, 1'b0);
    done_phase("lbu", 32'h0000_0080, 1'b0, 1'b0, 3);

    // LH from upper half: 0x8001 sign-extended.
    issue(1'b0, MEM_H, 1'b0, 32'h0000_2002, 32'h0);
    req_phase("lh", 0, 32'h0000_2000, 4'b1111, 32'h0, 1'b0);
    rsp_phase("lh", 32'h8001_1234, 1'b0);
    done_phase("lh", 32'hFFFF_8001, 1'b0, 1'b0, 3);

    // SH upper half with grant held off for 5 cycles.
    issue(1'b1, MEM_H, 1'b0, 32'h0000_2002, 32'h0000_1234);
    req_phase("sh", 5, 32'h0000_2000, 4'b1100, 32'h1234_1234, 1'b1);
    rsp_phase("sh", 32'h0, 1'b0);
    done_phase("sh", 32'h0, 1'b0, 1'b0, 8);

    // SB to lane 1.
    issue(1'b1, MEM_B, 1'b0, 32'h0000_2001, 32'h0000_00AB);
    req_phase("sb", 0, 32'h0000_2000, 4'b0010, 32'hABAB_ABAB, 1'b1);
    rsp_phase("sb", 32'h0, 1'b0);
    done_phase("sb", 32'h0, 1'b0, 1'b0, 3);

    // Misaligned LW: no bus access, done the cycle after accept.
    issue(1'b0, MEM_W, 1'b0, 32'h0000_2001, 32'h0);
    done_phase("lw_mis", 32'h0, 1'b1, 1'b0, 1);

    // Illegal width reports an error, not misalignment.
    issue(1'b0, 2'b11, 1'b0, 32'h0000_2000, 32'h0);
    done_phase("ill_w", 32'h0, 1'b0, 1'b1, 1);

    // LW with no response: 4 WAIT cycles then error completion.
    issue(1'b0, MEM_W, 1'b0, 32'h0000_3000, 32'h0);
    req_phase("lw_to", 0, 32'h0000_3000, 4'b1111, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lw_to_wait_done", {31'b0, lsu_done_o}, 32'h0);
      chk("lw_to_wait_busy", {31'b0, lsu_busy_o}, 32'h1);
      tick();
    end
    done_phase("lw_to", 32'h0, 1'b0, 1'b1, 6);

    // Bus error on the response.
    issue(1'b0, MEM_W, 1'b0, 32'h0000_2004, 32'h0);
    req_phase("lw_be", 0, 32'h0000_2004, 4'b1111, 32'h0, 1'b0);
    rsp_phase("lw_be", 32'h1234_5678, 1'b1);
    done_phase("lw_be", 32'h0, 1'b0, 1'b1, 3);

    // Plain LW.
    issue(1'b0, MEM_W, 1'b0, 32'h0000_2008, 32'h0);
    req_phase("lw", 0, 32'h0000_2008, 4'b1111, 32'h0, 1'b0);
    rsp_phase("lw", 32'hCAFE_F00D, 1'b0);
    done_phase("lw", 32'hCAFE_F00D, 1'b0, 1'b0, 3);

    // Reset while waiting for the response: abandon, no done pulse.
    issue(1'b0, MEM_W, 1'b0, 32'h0000_3000, 32'h0);
    req_phase("rst_w", 0, 32'h0000_3000, 4'b1111, 32'h0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstw_busy", {31'b0, lsu_busy_o}, 32'h0);
    chk("rstw_req",  {31'b0, bus.data_req_o}, 32'h0);
    chk("rstw_done", {31'b0, lsu_done_o}, 32'h0);
    chk("rstw_err",  {31'b0, lsu_err_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    lsu_req_i = 1'b0;
    bus.data_rvalid_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rstw_after_done", {31'b0, lsu_done_o}, 32'h0);
      chk("rstw_after_busy", {31'b0, lsu_busy_o}, 32'h0);
      tick();
    end
    bus.data_rvalid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
